// File: rtl/pipe_trace_monitor_pkg.sv
// Shared Y86 definitions used by the writeback-stage trace monitor:
// status encodings, special icode and register-id constants, FSM states.
package pipe_trace_monitor_pkg;

  typedef enum logic [1:0] {
    STAT_AOK = 2'd0,
    STAT_HLT = 2'd1,
    STAT_ADR = 2'd2,
    STAT_INS = 2'd3
  } stat_e;

  localparam logic [3:0] ICODE_NOP = 4'h1;
  localparam logic [3:0] REG_NONE  = 4'hF;

  typedef enum logic {
    ST_RUN  = 1'b0,
    ST_DONE = 1'b1
  } mon_state_e;

endpackage

// File: rtl/pipe_trace_monitor_fifo.sv
// Trace FIFO with first-word-fall-through read; full/empty resolved by an
// extra pointer bit. Push while full succeeds only alongside a pop.
module trace_fifo #(
  parameter int DEPTH = 16,
  parameter int WIDTH = 74
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] wr_data,
  output logic             rd_valid,
  output logic [WIDTH-1:0] rd_data,
  output logic             full
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] PTR_ONE = (AW + 1)'(1);

  logic [AW:0]      wptr_q, wptr_d;
  logic [AW:0]      rptr_q, rptr_d;
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic             empty;
  logic             do_push;
  logic             do_pop;

  assign empty = (wptr_q == rptr_q);
  assign full  = (wptr_q[AW] != rptr_q[AW]) && (wptr_q[AW-1:0] == rptr_q[AW-1:0]);

  always_comb begin
    do_pop  = pop && !empty;
    do_push = push && (!full || do_pop);
    wptr_d  = wptr_q;
    rptr_d  = rptr_q;
    if (clr) begin
      wptr_d = '0;
      rptr_d = '0;
    end else begin
      if (do_push) wptr_d = wptr_q + PTR_ONE;
      if (do_pop)  rptr_d = rptr_q + PTR_ONE;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr_q <= '0;
      rptr_q <= '0;
    end else begin
      wptr_q <= wptr_d;
      rptr_q <= rptr_d;
    end
  end

  // Storage carries no reset; validity is owned entirely by the pointers.
  always_ff @(posedge clk) begin
    if (do_push && !clr) mem_q[wptr_q[AW-1:0]] <= wr_data;
  end

  assign rd_valid = !empty;
  assign rd_data  = empty ? '0 : mem_q[rptr_q[AW-1:0]];

endmodule

// File: rtl/pipe_trace_monitor.sv
// Writeback-stage trace monitor: saturating performance counters, RUN/DONE
// FSM that stops on a non-AOK retirement, and a trace FIFO of retired results.
module pipe_trace_monitor
  import pipe_trace_monitor_pkg::*;
#(
  parameter int DEPTH = 16,
  parameter int CNT_W = 32,
  parameter int VAL_W = 64
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clr,
  input  logic [3:0]        W_icode,
  input  logic [1:0]        W_stat,
  input  logic [3:0]        W_dstE,
  input  logic [VAL_W-1:0]  W_valE,
  input  logic              W_stall,
  input  logic              F_stall,
  input  logic              D_stall,
  input  logic              D_bubble,
  input  logic              E_bubble,
  input  logic              M_bubble,
  input  logic              rd_ready,
  output logic              rd_valid,
  output logic [VAL_W+9:0]  rd_data,
  output logic [CNT_W-1:0]  cycle_cnt,
  output logic [CNT_W-1:0]  retire_cnt,
  output logic [CNT_W-1:0]  stall_cnt,
  output logic [CNT_W-1:0]  bubble_cnt,
  output logic [CNT_W-1:0]  drop_cnt,
  output logic              halted,
  output logic [1:0]        final_stat,
  output logic              overflow
);

  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + CNT_ONE;
  endfunction

  mon_state_e       state_q, state_d;
  logic [CNT_W-1:0] cycle_cnt_q, cycle_cnt_d;
  logic [CNT_W-1:0] retire_cnt_q, retire_cnt_d;
  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
  logic [CNT_W-1:0] bubble_cnt_q, bubble_cnt_d;
  logic [CNT_W-1:0] drop_cnt_q, drop_cnt_d;
  logic [1:0]       final_stat_q, final_stat_d;
  logic             overflow_q, overflow_d;
  logic             retire;
  logic             pop;
  logic             full;

  assign retire = (state_q == ST_RUN) && !W_stall && (W_icode != ICODE_NOP);
  assign pop    = rd_valid && rd_ready;

  always_comb begin
    state_d      = state_q;
    cycle_cnt_d  = cycle_cnt_q;
    retire_cnt_d = retire_cnt_q;
    stall_cnt_d  = stall_cnt_q;
    bubble_cnt_d = bubble_cnt_q;
    drop_cnt_d   = drop_cnt_q;
    final_stat_d = final_stat_q;
    overflow_d   = overflow_q;
    if (clr) begin
      state_d      = ST_RUN;
      cycle_cnt_d  = '0;
      retire_cnt_d = '0;
      stall_cnt_d  = '0;
      bubble_cnt_d = '0;
      drop_cnt_d   = '0;
      final_stat_d = STAT_AOK;
      overflow_d   = 1'b0;
    end else if (state_q == ST_RUN) begin
      cycle_cnt_d = sat_inc(cycle_cnt_q);
      if (retire) retire_cnt_d = sat_inc(retire_cnt_q);
      if (F_stall || D_stall || W_stall) stall_cnt_d = sat_inc(stall_cnt_q);
      if (D_bubble || E_bubble || M_bubble) bubble_cnt_d = sat_inc(bubble_cnt_q);
      if (retire && full && !pop) begin
        drop_cnt_d = sat_inc(drop_cnt_q);
        overflow_d = 1'b1;
      end
      // The faulting instruction is still traced; the stop takes effect next edge.
      if (retire && (W_stat != STAT_AOK)) begin
        state_d      = ST_DONE;
        final_stat_d = W_stat;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_RUN;
      cycle_cnt_q  <= '0;
      retire_cnt_q <= '0;
      stall_cnt_q  <= '0;
      bubble_cnt_q <= '0;
      drop_cnt_q   <= '0;
      final_stat_q <= STAT_AOK;
      overflow_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      cycle_cnt_q  <= cycle_cnt_d;
      retire_cnt_q <= retire_cnt_d;
      stall_cnt_q  <= stall_cnt_d;
      bubble_cnt_q <= bubble_cnt_d;
      drop_cnt_q   <= drop_cnt_d;
      final_stat_q <= final_stat_d;
      overflow_q   <= overflow_d;
    end
  end

  trace_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (VAL_W + 10)
  ) u_fifo (
    .clk      (clk),
    .rst_n    (rst_n),
    .clr      (clr),
    .push     (retire),
    .pop      (pop),
    .wr_data  ({W_icode, W_dstE, W_stat, W_valE}),
    .rd_valid (rd_valid),
    .rd_data  (rd_data),
    .full     (full)
  );

  assign cycle_cnt  = cycle_cnt_q;
  assign retire_cnt = retire_cnt_q;
  assign stall_cnt  = stall_cnt_q;
  assign bubble_cnt = bubble_cnt_q;
  assign drop_cnt   = drop_cnt_q;
  assign halted     = (state_q == ST_DONE);
  assign final_stat = final_stat_q;
  assign overflow   = overflow_q;

endmodule

// File: doc/pipe_trace_monitor.md
PIPE_TRACE_MONITOR -- requirements
Module: pipe_trace_monitor

Interface
REQ-001 Parameters SHALL be: DEPTH, 16, trace FIFO entries (power of two, >=2); CNT_W, 32, width of every performance counter; VAL_W, 64, width of traced result value.
REQ-002 Ports SHALL be: clk  in  1  single clock, all state on rising edge.
REQ-003 rst_n  in  1  reset, asynchronous assert, active low.
REQ-004 clr  in  1  synchronous clear of counters, FIFO, flags and state.
REQ-005 W_icode  in  4  writeback-stage instruction code.
REQ-006 W_stat  in  2  writeback-stage status: AOK=0, HLT=1, ADR=2, INS=3.
REQ-007 W_dstE  in  4  writeback-stage destination register (0xF = none).
REQ-008 W_valE  in  VAL_W  writeback-stage result value.
REQ-009 W_stall, F_stall, D_stall  in  1 each  pipeline stall controls.
REQ-010 D_bubble, E_bubble, M_bubble  in  1 each  pipeline bubble controls.
REQ-011 rd_ready  in  1  consumer accepts trace entry.
REQ-012 rd_valid  out  1  trace entry available.
REQ-013 rd_data  out  10+VAL_W  entry {icode[3:0], dstE[3:0], stat[1:0], valE}.
REQ-014 cycle_cnt, retire_cnt, stall_cnt, bubble_cnt, drop_cnt  out  CNT_W each  performance counters.
REQ-015 halted  out  1  high in DONE state; final_stat  out  2  status that ended the run.
REQ-016 overflow  out  1  sticky, set when any retire event was dropped.

Function
REQ-017 State machine SHALL have two states: RUN, DONE; reset and clr enter RUN.
REQ-018 Retire event SHALL be: state RUN, W_stall=0, W_icode!=4'h1 (nop/bubble).
REQ-019 In RUN, cycle_cnt SHALL increment every cycle; retire_cnt on each retire event; stall_cnt when any of F_stall, D_stall, W_stall is high; bubble_cnt when any of D_bubble, E_bubble, M_bubble is high (one count per cycle, not per signal).
REQ-020 All counters SHALL saturate at 2^CNT_W-1, never wrap.
REQ-021 A retire event with W_stat!=AOK SHALL be traced and counted, then move to DONE with final_stat=W_stat on the next edge.
REQ-022 In DONE, all counters SHALL freeze and no entries SHALL be pushed; FIFO draining continues; only clr or reset leaves DONE.
REQ-023 Each retire event SHALL push one entry; entry visible on rd_valid the cycle after the push edge (1-cycle latency).
REQ-024 Pop SHALL occur on an edge where rd_valid && rd_ready; rd_data SHALL hold steady while rd_valid && !rd_ready.
REQ-025 Push while full without a simultaneous pop SHALL drop the entry, increment drop_cnt and set overflow.
REQ-026 Push and pop on the same edge while full SHALL both succeed; occupancy unchanged.
REQ-027 Push and pop on the same edge while exactly one entry SHALL leave rd_valid high with the new entry.
REQ-028 Read/write pointers SHALL wrap modulo DEPTH; full/empty distinguished by an extra pointer bit.
REQ-029 clr SHALL take priority over every simultaneous event that cycle.

Reset
REQ-030 While rst_n=0: state RUN, all counters 0, FIFO empty, rd_valid=0, rd_data=0, halted=0, final_stat=AOK, overflow=0.
REQ-031 Reset asserted mid-run SHALL discard FIFO contents immediately without waiting for clk.

Structure
REQ-032 Status encodings (AOK/HLT/ADR/INS), icode constant NOP=4'h1 and register-none 4'hF SHALL live in the shared Y86 package.
REQ-033 The FIFO SHALL be a sub-module trace_fifo (parameters DEPTH, WIDTH); counters and FSM stay in the top.

Verification
REQ-034 Reset then 5 retires (icode 6, dstE 3, valE 1..5), rd_ready=1 -> retire_cnt=5, five entries popped in order, valE 1..5.
REQ-035 rd_ready=0, DEPTH=16, 20 retires -> 16 entries held, drop_cnt=4, overflow=1; then drain -> first 16 values in order.
REQ-036 Full FIFO, rd_ready=1 plus retire same cycle -> drop_cnt unchanged, occupancy stays 16.
REQ-037 Retire with W_stat=HLT -> halted=1 next cycle, final_stat=1; further cycles leave cycle_cnt frozen, no new entries.
REQ-038 F_stall and D_bubble both high 3 cycles, W_icode=1 -> stall_cnt=3, bubble_cnt=3, retire_cnt=0.
REQ-039 rst_n low mid-run with 4 entries queued -> rd_valid=0 and all counters 0 before next clk edge.
